// File: rtl/stabilizer_row_buffer.sv
// Stabilizer tableau row buffer: fills num_qubit rows, drains them in write order
// through the bottom-row tap, and supports idle-time row/column rotations.
module stabilizer_row_buffer #(
   parameter int num_qubit  = 4,
   parameter int max_vector = 2**num_qubit
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   input  logic [2*num_qubit-1:0]         in_literals,
   input  logic [max_vector-1:0]          in_phase,
   output logic                           in_ready,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [2*num_qubit-1:0]         out_literals,
   output logic [max_vector-1:0]          out_phase,
   input  logic                           rotate_down,
   input  logic                           rotate_left,
   input  logic                           rotate_right,
   input  logic                           flush,
   output logic [$clog2(num_qubit+1)-1:0] count,
   output logic                           busy,
   output logic                           overflow_err
);
   localparam int CW = $clog2(num_qubit+1);
   localparam logic [CW-1:0] FULL = CW'(num_qubit);
   localparam logic [CW-1:0] ONE  = CW'(1);

   typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

   state_t                                     state_q;
   logic [num_qubit-1:0][num_qubit-1:0][1:0]   lit_q, lit_d;
   logic [num_qubit-1:0][max_vector-1:0]       ph_q, ph_d;
   logic [CW-1:0]                              count_q;
   logic                                       in_ready_q, out_valid_q, busy_q, ovf_q;
   logic                                       wr_en, drain_en, rot_en;

   assign wr_en    = in_valid && in_ready_q && !flush;
   assign drain_en = out_valid_q && out_ready && !flush;
   assign rot_en   = (state_q == IDLE) && !flush && !wr_en;

   // Write, drain and rotate_down share one down-shift; only the row-0 source differs.
   always_comb begin
      lit_d = lit_q;
      ph_d  = ph_q;
      if (wr_en || drain_en || (rot_en && rotate_down)) begin
         lit_d[0] = wr_en ? in_literals : lit_q[num_qubit-1];
         ph_d[0]  = wr_en ? in_phase    : ph_q[num_qubit-1];
         for (int i = 1; i < num_qubit; i++) begin
            lit_d[i] = lit_q[i-1];
            ph_d[i]  = ph_q[i-1];
         end
      end else if (rot_en && rotate_left) begin
         for (int i = 0; i < num_qubit; i++)
            for (int j = 0; j < num_qubit; j++)
               lit_d[i][j] = lit_q[i][(j+1) % num_qubit];
      end else if (rot_en && rotate_right) begin
         for (int i = 0; i < num_qubit; i++)
            for (int j = 0; j < num_qubit; j++)
               lit_d[i][j] = lit_q[i][(j+num_qubit-1) % num_qubit];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         lit_q       <= '0;
         ph_q        <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         lit_q <= lit_d;
         ph_q  <= ph_d;
         if (in_valid && !in_ready_q)
            ovf_q <= 1'b1;
         if (flush) begin
            state_q     <= IDLE;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
         end else begin
            case (state_q)
               IDLE, FILL: if (wr_en) begin
                  count_q <= count_q + ONE;
                  busy_q  <= 1'b1;
                  if (count_q + ONE == FULL) begin
                     state_q     <= DRAIN;
                     out_valid_q <= 1'b1;
                     in_ready_q  <= 1'b0;
                  end else begin
                     state_q <= FILL;
                  end
               end
               DRAIN: if (drain_en) begin
                  count_q <= count_q - ONE;
                  if (count_q == ONE) begin
                     state_q     <= IDLE;
                     out_valid_q <= 1'b0;
                     in_ready_q  <= 1'b1;
                     busy_q      <= 1'b0;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign busy         = busy_q;
   assign overflow_err = ovf_q;
   assign count        = count_q;
   assign out_literals = lit_q[num_qubit-1];
   assign out_phase    = ph_q[num_qubit-1];
endmodule

// File: tb/tb_stabilizer_row_buffer.sv
// Randomized bench for stabilizer_row_buffer: a row-list model predicts status and
// drained rows; a negedge monitor pops drained rows from a scoreboard queue.
module tb_stabilizer_row_buffer;
   localparam int N  = 4;
   localparam int MV = 16;
   localparam int CW = $clog2(N+1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst, in_valid, in_ready, out_valid, out_ready;
   logic [2*N-1:0]  in_literals, out_literals;
   logic [MV-1:0]   in_phase, out_phase;
   logic            rotate_down, rotate_left, rotate_right, flush, busy, overflow_err;
   logic [CW-1:0]   count;

   stabilizer_row_buffer #(.num_qubit(N), .max_vector(MV)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_literals(in_literals),
      .in_phase(in_phase), .in_ready(in_ready), .out_valid(out_valid),
      .out_ready(out_ready), .out_literals(out_literals), .out_phase(out_phase),
      .rotate_down(rotate_down), .rotate_left(rotate_left), .rotate_right(rotate_right),
      .flush(flush), .count(count), .busy(busy), .overflow_err(overflow_err));

   typedef struct packed {
      logic [2*N-1:0] lit;
      logic [MV-1:0]  ph;
   } row_t;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   // Model: rows as a plain list (index 0 = newest), a row count, a drain flag, sticky error.
   logic [2*N-1:0] m_lit [N];
   logic [MV-1:0]  m_ph  [N];
   int             m_cnt;
   bit             m_drain, m_ovf;
   row_t           exp_q [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2*N-1:0] col_rotl(input logic [2*N-1:0] v);
      logic [2*N-1:0] lo;
      lo = {{(2*N-2){1'b0}}, v[1:0]};
      return (v >> 2) | (lo << (2*N-2));
   endfunction

   function automatic logic [2*N-1:0] col_rotr(input logic [2*N-1:0] v);
      logic [2*N-1:0] hi;
      hi = {{(2*N-2){1'b0}}, v[2*N-1:2*N-2]};
      return (v << 2) | hi;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < N; i++) begin
         m_lit[i] = '0;
         m_ph[i]  = '0;
      end
      m_cnt = 0; m_drain = 0; m_ovf = 0;
   endtask

   task automatic m_push_front(input logic [2*N-1:0] l, input logic [MV-1:0] p);
      for (int i = N-1; i > 0; i--) begin
         m_lit[i] = m_lit[i-1];
         m_ph[i]  = m_ph[i-1];
      end
      m_lit[0] = l;
      m_ph[0]  = p;
   endtask

   // Called just after a rising edge: check status against the model, drive one cycle.
   task automatic step(input bit r, input bit iv, input logic [2*N-1:0] il,
                       input logic [MV-1:0] ip, input bit ordy, input bit rd,
                       input bit rl, input bit rr, input bit fl);
      bit   rdy;
      row_t e;
      rdy = !m_drain && (m_cnt < N);
      chk("in_ready",     64'(in_ready),     64'(rdy));
      chk("out_valid",    64'(out_valid),    64'(m_drain));
      chk("busy",         64'(busy),         64'(m_cnt != 0));
      chk("count",        64'(count),        64'(m_cnt));
      chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
      chk("out_literals", 64'(out_literals), 64'(m_lit[N-1]));
      chk("out_phase",    64'(out_phase),    64'(m_ph[N-1]));
      rst = r; in_valid = iv; in_literals = il; in_phase = ip; out_ready = ordy;
      rotate_down = rd; rotate_left = rl; rotate_right = rr; flush = fl;
      if (!r) begin
         m_reset();
      end else begin
         if (iv && !rdy) m_ovf = 1;
         if (fl) begin
            m_cnt = 0; m_drain = 0;
         end else if (iv && rdy) begin
            m_push_front(il, ip);
            m_cnt++;
            if (m_cnt == N) m_drain = 1;
         end else if (m_drain && ordy) begin
            e.lit = m_lit[N-1];
            e.ph  = m_ph[N-1];
            exp_q.push_back(e);
            m_push_front(e.lit, e.ph);
            m_cnt--;
            if (m_cnt == 0) m_drain = 0;
         end else if (m_cnt == 0) begin
            if (rd) m_push_front(m_lit[N-1], m_ph[N-1]);
            else if (rl) for (int i = 0; i < N; i++) m_lit[i] = col_rotl(m_lit[i]);
            else if (rr) for (int i = 0; i < N; i++) m_lit[i] = col_rotr(m_lit[i]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic nop(input bit ordy);
      step(1, 0, '0, '0, ordy, 0, 0, 0, 0);
   endtask

   task automatic wrow(input logic [2*N-1:0] l);
      step(1, 1, l, MV'($urandom), 0, 0, 0, 0, 0);
   endtask

   task automatic do_flush();
      step(1, 0, '0, '0, 0, 0, 0, 0, 1);
   endtask

   // Drain scoreboard: a handshake is committed at the next rising edge.
   row_t got;
   always @(negedge clk) begin
      if (rst && !flush && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_unexpected: got row %0h, expected none", out_literals);
         end else begin
            got = exp_q.pop_front();
            chk("drain_lit", 64'(out_literals), 64'(got.lit));
            chk("drain_ph",  64'(out_phase),    64'(got.ph));
         end
      end
   end

   initial begin
      rst = 0; in_valid = 0; in_literals = '0; in_phase = '0; out_ready = 0;
      rotate_down = 0; rotate_left = 0; rotate_right = 0; flush = 0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      step(0, 1, 8'hFF, 16'hFFFF, 1, 1, 1, 1, 0);
      nop(0);

      // Fill with 00,55,AA,FF and drain in write order.
      wrow(8'h00); wrow(8'h55); wrow(8'hAA); wrow(8'hFF);
      chk("valid_after_fill", 64'(out_valid), 64'(1));
      chk("first_out", 64'(out_literals), 64'h00);
      repeat (4) nop(1);
      chk("idle_after_drain", 64'(busy), 64'(0));
      repeat (4) step(1, 0, '0, '0, 0, 1, 0, 0, 0);

      // Stall for 5 cycles in DRAIN, then resume.
      repeat (4) wrow(8'($urandom));
      repeat (5) nop(0);
      chk("stall_count", 64'(count), 64'(N));
      repeat (4) nop(1);

      // Column rotations on a known row.
      wrow(8'h1B);
      do_flush();
      repeat (3) step(1, 0, '0, '0, 0, 1, 0, 0, 0);
      chk("row0_at_tap", 64'(out_literals), 64'h1B);
      step(1, 0, '0, '0, 0, 0, 1, 0, 0);
      chk("rotl_1B", 64'(out_literals), 64'hC6);
      step(1, 0, '0, '0, 0, 0, 0, 1, 0);
      chk("rotr_C6", 64'(out_literals), 64'h1B);
      step(1, 0, '0, '0, 0, 1, 1, 1, 0);
      step(1, 1, 8'h3C, 16'h1234, 0, 1, 1, 0, 0);
      do_flush();

      // Write attempt while draining sets the sticky error.
      repeat (4) wrow(8'($urandom));
      step(1, 1, 8'hEE, 16'hBEEF, 0, 0, 0, 0, 0);
      chk("ovf_set", 64'(overflow_err), 64'(1));
      do_flush();
      chk("ovf_sticky", 64'(overflow_err), 64'(1));
      nop(0);

      // Partial fill then flush; then reset in the middle of a drain.
      wrow(8'h12); wrow(8'h34);
      do_flush();
      chk("flush_count", 64'(count), 64'(0));
      chk("flush_busy", 64'(busy), 64'(0));
      repeat (4) wrow(8'($urandom));
      nop(1);
      step(0, 1, 8'h77, 16'h7777, 1, 1, 0, 0, 1);
      step(1, 0, '0, '0, 0, 0, 0, 0, 0);
      chk("rst_tap_zero", 64'(out_literals), 64'h0);
      chk("rst_ovf", 64'(overflow_err), 64'(0));
      repeat (4) step(1, 0, '0, '0, 0, 1, 0, 0, 0);

      // Random traffic.
      for (int k = 0; k < 600; k++) begin
         step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 45),
              8'($urandom), MV'($urandom), ($urandom_range(0, 99) < 60),
              ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 20),
              ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 4));
      end
      nop(0);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/stabilizer_row_buffer.md
STABILIZER_ROW_BUFFER -- requirements
Module: stabilizer_row_buffer

Interface
REQ-001 Parameter num_qubit, default 4: rows in the array, and literal columns per row.
REQ-002 Parameter max_vector, default 2**num_qubit: phase bits per row.
REQ-003 clk  input  1  rising-edge clock; sole clock.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  row write request.
REQ-006 in_literals  input  2 x num_qubit  literal row to write.
REQ-007 in_phase  input  1 x max_vector  phase row to write.
REQ-008 in_ready  output  1  buffer accepts a row this cycle.
REQ-009 out_valid  output  1  row num_qubit-1 presented for drain.
REQ-010 out_ready  input  1  consumer accepts the presented row.
REQ-011 out_literals  output  2 x num_qubit  literals of row num_qubit-1, always driven.
REQ-012 out_phase  output  1 x max_vector  phases of row num_qubit-1, always driven.
REQ-013 rotate_down  input  1  rotate rows down by one position.
REQ-014 rotate_left  input  1  rotate literal columns left; phases untouched.
REQ-015 rotate_right  input  1  rotate literal columns right; phases untouched.
REQ-016 flush  input  1  abort fill or drain and return to IDLE.
REQ-017 count  output  $clog2(num_qubit+1)  rows currently held.
REQ-018 busy  output  1  high whenever state is not IDLE.
REQ-019 overflow_err  output  1  sticky flag: a write was attempted while in_ready was 0.

Function
REQ-020 Row storage SHALL be literal_reg[row][col] (2 bits each) and phase_reg[row][max_vector].
REQ-021 FSM states SHALL be IDLE (count==0), FILL (0<count<num_qubit) and DRAIN.
REQ-022 in_ready SHALL equal (state!=DRAIN) && (count<num_qubit).
REQ-023 A write SHALL be accepted when in_valid&&in_ready: row 0 <= input, row i <= row i-1, count+1.
REQ-024 IDLE SHALL move to FILL on an accepted write; FILL SHALL move to DRAIN on the cycle after count reaches num_qubit.
REQ-025 out_valid SHALL be 1 exactly while in DRAIN; the first out_valid cycle is the cycle after the num_qubit-th accepted write.
REQ-026 In DRAIN, each out_valid&&out_ready cycle SHALL rotate rows down (row 0 <= row num_qubit-1, row i <= row i-1) and decrement count.
REQ-027 After num_qubit drain handshakes, the FSM SHALL return to IDLE with count 0 and rows back in their original order.
REQ-028 With out_ready low in DRAIN, the FSM SHALL stall and hold out_literals and out_phase stable.
REQ-029 rotate_down, rotate_left and rotate_right SHALL take effect only in IDLE, with no accepted write, priority down > left > right, one step per cycle.
REQ-030 rotate_left: literal_reg[i][j] <= [i][j+1] and [i][num_qubit-1] <= [i][0]; rotate_right is the inverse.
REQ-031 rotate_down SHALL move both literals and phases; rotates in FILL or DRAIN SHALL be ignored.
REQ-032 In IDLE, an accepted write SHALL win over any rotate asserted in the same cycle.
REQ-033 in_valid with in_ready==0 SHALL set overflow_err, leave the array and count unchanged, and overflow_err SHALL clear only on reset.
REQ-034 flush SHALL have highest priority: next state IDLE, count 0, out_valid 0, array contents retained, no write or rotate that cycle.
REQ-035 All outputs SHALL be registered state or direct row taps; no combinational path from in_valid to out_valid.

Reset
REQ-036 When rst==0 at a clk edge: all literal_reg and phase_reg SHALL be 0, state IDLE, count 0.
REQ-037 During reset: out_valid 0, busy 0, overflow_err 0, and in_ready SHALL be 1 from the first cycle after reset.
REQ-038 Reset asserted mid-FILL or mid-DRAIN SHALL take precedence over all inputs, with no partial update.

Verification (num_qubit=4, max_vector=16)
REQ-039 Write rows with literals 0x00,0x55,0xAA,0xFF -> out_valid rises one cycle after the 4th write; drain order 0x00,0x55,0xAA,0xFF; count 4->0; IDLE; array order restored.
REQ-040 In DRAIN, hold out_ready low 5 cycles -> out_literals stable, count stays 4, out_valid stays 1; release -> drain resumes.
REQ-041 In IDLE with row 0 literals 0x1B, rotate_left -> 0xC6; rotate_right -> 0x1B again; phase rows unchanged.
REQ-042 During DRAIN, pulse in_valid -> overflow_err=1 and stays 1 through a later flush; array unaffected.
REQ-043 After 2 writes, flush -> IDLE, count 0, busy 0; rst low mid-DRAIN -> all rows 0 and outputs at reset values.
